mem_arbiter: RTL

- Sole master of the CPU's byte-wide RAM/IO port (mem_din, mem_dout, mem_a, mem_wr, io_buffer_full) inside the cpu core under riscv_top.
- Shares that port between two requesters:
  - instruction fetch (IF), which reads 32-bit words;
  - load/store buffer (LS), which does 1/2/4-byte reads and writes.
- Serialises each access into byte transactions, honours rdy_in and the UART io_buffer_full backpressure, and aborts speculative reads on clear_in.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU byte-wide memory port arbiter and its clients.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_t;

    typedef enum logic {
        GR_IF = 1'b0,
        GR_LS = 1'b1
    } grant_t;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] IO_SEL = 2'b11;

    // Takes addr[17:16]; the rest of the address never selects IO space.
    function automatic logic is_io(input logic [1:0] page, input logic [1:0] sel);
        return page == sel;
    endfunction

    // Index of the final byte of an access; the illegal size 3 behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// RAM/IO port plus the instruction-fetch and load/store request channels.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ready;
    logic [31:0]           if_data;

    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [1:0]            ls_size;
    logic [31:0]           ls_wdata;
    logic                  ls_ready;
    logic [31:0]           ls_rdata;

    modport master (
        input  mem_din, io_buffer_full,
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_size, ls_wdata,
        output mem_dout, mem_a, mem_wr,
        output if_ready, if_data,
        output ls_ready, ls_rdata
    );

    modport slave (
        output mem_din, io_buffer_full,
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_size, ls_wdata,
        input  mem_dout, mem_a, mem_wr,
        input  if_ready, if_data,
        input  ls_ready, ls_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising IF word reads and LS 1/2/4-byte accesses onto a byte RAM port.
// Latency: N-byte read completes N edges after accept (ready pulses cycle N+1); writes likewise.
// Backpressure: rdy_in low freezes everything; IO writes stall while io_buffer_full is high.
module mem_arbiter #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_SEL     = 2'b11
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_in,
    mem_arbiter_if.master bus
);
    import mem_pkg::*;

    state_t                state_q;
    grant_t                last_q;
    logic [1:0]            cnt_q;
    logic [1:0]            last_idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            dout_q;
    logic                  mem_wr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;
    logic [31:0]           if_data_q;
    logic [31:0]           ls_rdata_q;
    logic                  if_ready_q;
    logic                  ls_ready_q;
    logic                  ls_io_q;

    logic                  if_elig, ls_elig, grant_if, grant_ls;
    logic [1:0]            cnt_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [31:0]           rd_word;
    logic [7:0]            wr_byte;
    logic                  rd_abort;
    logic                  acc_wr_hold, cur_wr_hold, nx_wr_hold;

    assign if_elig  = bus.if_req & ~if_ready_q & ~clear_in;
    assign ls_elig  = bus.ls_req & ~ls_ready_q;
    assign grant_if = if_elig & (~ls_elig | (last_q == GR_LS));
    assign grant_ls = ls_elig & ~grant_if;

    assign cnt_nx  = cnt_q + 2'd1;
    assign addr_nx = addr_q + ADDR_WIDTH'(cnt_nx);

    // IO reads have side effects once issued, so only non-IO LS reads may be dropped.
    assign rd_abort = clear_in & ((state_q == ST_IF_RD) | ~ls_io_q);

    assign acc_wr_hold = is_io(bus.ls_addr[17:16], IO_SEL) & bus.io_buffer_full;
    assign cur_wr_hold = is_io(mem_a_q[17:16], IO_SEL) & bus.io_buffer_full;
    assign nx_wr_hold  = is_io(addr_nx[17:16], IO_SEL) & bus.io_buffer_full;

    always_comb begin
        rd_word = rbuf_q;
        case (cnt_q)
            2'd0:    rd_word[7:0]   = bus.mem_din;
            2'd1:    rd_word[15:8]  = bus.mem_din;
            2'd2:    rd_word[23:16] = bus.mem_din;
            default: rd_word[31:24] = bus.mem_din;
        endcase
    end

    always_comb begin
        wr_byte = wdata_q[7:0];
        case (cnt_nx)
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            last_q     <= GR_LS;
            cnt_q      <= 2'd0;
            last_idx_q <= 2'd0;
            addr_q     <= '0;
            mem_a_q    <= '0;
            dout_q     <= 8'd0;
            mem_wr_q   <= 1'b0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            if_data_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            ls_io_q    <= 1'b0;
        end else if (rdy_in) begin
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_if) begin
                        state_q    <= ST_IF_RD;
                        last_q     <= GR_IF;
                        addr_q     <= bus.if_addr;
                        mem_a_q    <= bus.if_addr;
                        cnt_q      <= 2'd0;
                        last_idx_q <= 2'd3;
                        rbuf_q     <= 32'd0;
                    end else if (grant_ls) begin
                        state_q    <= bus.ls_we ? ST_LS_WR : ST_LS_RD;
                        last_q     <= GR_LS;
                        addr_q     <= bus.ls_addr;
                        mem_a_q    <= bus.ls_addr;
                        cnt_q      <= 2'd0;
                        last_idx_q <= last_idx(bus.ls_size);
                        rbuf_q     <= 32'd0;
                        ls_io_q    <= is_io(bus.ls_addr[17:16], IO_SEL);
                        wdata_q    <= bus.ls_wdata;
                        if (bus.ls_we) begin
                            dout_q   <= bus.ls_wdata[7:0];
                            mem_wr_q <= ~acc_wr_hold;
                        end
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    if (rd_abort) begin
                        state_q <= ST_IDLE;
                        mem_a_q <= '0;
                    end else if (cnt_q == last_idx_q) begin
                        state_q <= ST_IDLE;
                        mem_a_q <= '0;
                        if (state_q == ST_IF_RD) begin
                            if_data_q  <= rd_word;
                            if_ready_q <= 1'b1;
                        end else begin
                            ls_rdata_q <= rd_word;
                            ls_ready_q <= 1'b1;
                        end
                    end else begin
                        rbuf_q  <= rd_word;
                        cnt_q   <= cnt_nx;
                        mem_a_q <= addr_nx;
                    end
                end
                ST_LS_WR: begin
                    // mem_wr_q low here means the current byte is still waiting on the UART.
                    if (mem_wr_q) begin
                        if (cnt_q == last_idx_q) begin
                            state_q    <= ST_IDLE;
                            mem_wr_q   <= 1'b0;
                            mem_a_q    <= '0;
                            ls_ready_q <= 1'b1;
                        end else begin
                            cnt_q    <= cnt_nx;
                            mem_a_q  <= addr_nx;
                            dout_q   <= wr_byte;
                            mem_wr_q <= ~nx_wr_hold;
                        end
                    end else if (!cur_wr_hold) begin
                        mem_wr_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = dout_q;
    assign bus.mem_wr   = mem_wr_q & rdy_in;
    assign bus.if_ready = if_ready_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_ready = ls_ready_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule
